// File: rtl/pc_ctrl.sv
// pc_ctrl -- program counter sequencer with IDLE / RUN / HALTED control.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       asynchronous, active-high; forces IDLE and zeroes every output
//   start       begin execution at address 0 (sampled in IDLE or HALTED)
//   halt_req    decoded halt instruction; enter HALTED
//   stall       hold PC and counters for this cycle
//   branch_en   current instruction is a conditional branch
//   one         ALU compare flag; 1 means the branch is taken
//   target_idx  branch operand: table index or 5-bit signed offset
//   prog_ctr    current instruction address (PC_W bits)
//   running     registered, high while in RUN
//   done        registered, high while in HALTED
//   taken_cnt   taken-branch count, saturating at 255
//   instr_cnt   retired-instruction count, saturating at 65535
//
// Build option
//   BR_LUT_EN   when defined, target_idx selects a signed offset from a
//               constant LUT_DEPTH-entry table; otherwise target_idx itself
//               is the offset, sign-extended to PC_W.
module pc_ctrl #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            one,
  input  logic [4:0]      target_idx,
  output logic [PC_W-1:0] prog_ctr,
  output logic            running,
  output logic            done,
  output logic [7:0]      taken_cnt,
  output logic [15:0]     instr_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]        pc_nxt;
  logic [7:0]             taken_nxt;
  logic [15:0]            instr_nxt;
  logic signed [PC_W-1:0] br_off;

  // Reject configurations the offset path cannot represent.
  if (PC_W < 5 || LUT_DEPTH < 1) begin : g_bad_cfg
    $error("pc_ctrl: PC_W must be >= 5 and LUT_DEPTH >= 1");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef BR_LUT_EN
  // Constant offset table: lower half forward offsets, upper half backward.
  function automatic logic signed [PC_W-1:0] lut_init(input int i);
    return (i < LUT_DEPTH / 2) ? PC_W'(i) : PC_W'(i - LUT_DEPTH);
  endfunction

  logic signed [PC_W-1:0] br_lut [LUT_DEPTH];

  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
    assign br_lut[gi] = lut_init(gi);
  end

  // Indices past the end of a short table read as a zero offset.
  always_comb begin
    br_off = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (int'(target_idx) == i) br_off = br_lut[i];
    end
  end
`else
  assign br_off = {{(PC_W-5){target_idx[4]}}, target_idx};
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    taken_nxt = taken_cnt;
    instr_nxt = instr_cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          taken_nxt = '0;
          instr_nxt = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALTED;
          instr_nxt = sat_inc16(instr_cnt);
        end else if (stall) begin
          // everything holds
        end else if (branch_en && one) begin
          // An X/Z flag fails this test and falls through to increment.
          pc_nxt    = prog_ctr + $unsigned(br_off);
          taken_nxt = sat_inc8(taken_cnt);
          instr_nxt = sat_inc16(instr_cnt);
        end else begin
          pc_nxt    = prog_ctr + PC_W'(1);
          instr_nxt = sat_inc16(instr_cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // running/done come from the next state so they are flops, not decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      taken_cnt <= '0;
      instr_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      prog_ctr  <= pc_nxt;
      taken_cnt <= taken_nxt;
      instr_cnt <= instr_nxt;
      running   <= (state_nxt == RUN);
      done      <= (state_nxt == HALTED);
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        stall;
  logic        branch_en;
  logic        one;
  logic [4:0]  target_idx;
  logic [9:0]  prog_ctr;
  logic        running;
  logic        done;
  logic [7:0]  taken_cnt;
  logic [15:0] instr_cnt;

  int tests = 0;
  int fails = 0;

  pc_ctrl #(.PC_W(10), .LUT_DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .stall      (stall),
    .branch_en  (branch_en),
    .one        (one),
    .target_idx (target_idx),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .taken_cnt  (taken_cnt),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [9:0] pc, input logic run,
                         input logic dn, input logic [7:0] tk, input logic [15:0] ic);
    chk({tag, ".pc"},    32'(prog_ctr),  32'(pc));
    chk({tag, ".run"},   32'(running),   32'(run));
    chk({tag, ".done"},  32'(done),      32'(dn));
    chk({tag, ".taken"}, 32'(taken_cnt), 32'(tk));
    chk({tag, ".instr"}, 32'(instr_cnt), 32'(ic));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch_en = 1'b0; one = 1'b0; target_idx = 5'd0;
    tick(); tick();
    chk_all("reset", 10'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    // IDLE with no start holds everything.
    reset = 1'b0;
    tick(); tick();
    chk_all("idle_hold", 10'd0, 1'b0, 1'b0, 8'd0, 16'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start", 10'd0, 1'b1, 1'b0, 8'd0, 16'd0);

    repeat (37) tick();
    chk_all("run37", 10'd37, 1'b1, 1'b0, 8'd0, 16'd37);

    // Asynchronous reset mid-RUN; start during reset must be ignored.
    #2 reset = 1'b1; start = 1'b1;
    #1;
    chk_all("async_rst", 10'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    tick();
    chk_all("rst_ignore", 10'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    reset = 1'b0;
    tick();
    start = 1'b0;
    chk("restart.pc0", 32'(prog_ctr), 32'd0);
    chk("restart.run", 32'(running), 32'd1);
    tick();
    chk("restart.pc1", 32'(prog_ctr), 32'd1);
    tick();
    chk_all("restart2", 10'd2, 1'b1, 1'b0, 8'd0, 16'd2);

    repeat (98) tick();
    chk("pc100", 32'(prog_ctr), 32'd100);

    // Taken branch, offset -4.
    branch_en = 1'b1; one = 1'b1; target_idx = 5'b11100;
    tick();
    chk_all("br_taken", 10'd96, 1'b1, 1'b0, 8'd1, 16'd101);
    one = 1'b0;
    tick();
    chk_all("br_not", 10'd97, 1'b1, 1'b0, 8'd1, 16'd102);
    one = 1'bx;
    tick();
    chk_all("br_x", 10'd98, 1'b1, 1'b0, 8'd1, 16'd103);
    branch_en = 1'b0; one = 1'b0;

    // Sequential wrap 1023 -> 0.
    repeat (925) tick();
    chk("pc1023", 32'(prog_ctr), 32'd1023);
    tick();
    chk_all("wrap", 10'd0, 1'b1, 1'b0, 8'd1, 16'd1029);
    tick(); tick();
    branch_en = 1'b1; one = 1'b1; target_idx = 5'b11100;
    tick();
    branch_en = 1'b0; one = 1'b0;
    chk_all("br_wrap", 10'd1022, 1'b1, 1'b0, 8'd2, 16'd1032);

    // Stall at pc 8.
    repeat (10) tick();
    chk("pc8", 32'(prog_ctr), 32'd8);
    stall = 1'b1;
    branch_en = 1'b1; one = 1'b1; target_idx = 5'd3;
    repeat (3) tick();
    chk_all("stall", 10'd8, 1'b1, 1'b0, 8'd2, 16'd1042);
    stall = 1'b0; branch_en = 1'b0; one = 1'b0;
    tick();
    chk_all("unstall", 10'd9, 1'b1, 1'b0, 8'd2, 16'd1043);

    // Halt wins over stall and a taken branch.
    halt_req = 1'b1; stall = 1'b1; branch_en = 1'b1; one = 1'b1; target_idx = 5'd3;
    tick();
    halt_req = 1'b0; stall = 1'b0; branch_en = 1'b0; one = 1'b0;
    chk_all("halt", 10'd9, 1'b0, 1'b1, 8'd2, 16'd1044);
    tick(); tick();
    chk_all("halted_hold", 10'd9, 1'b0, 1'b1, 8'd2, 16'd1044);

    // Restart from HALTED, then 300 self-loop branches.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart_h", 10'd0, 1'b1, 1'b0, 8'd0, 16'd0);
    branch_en = 1'b1; one = 1'b1; target_idx = 5'd0;
    repeat (300) tick();
    chk_all("sat", 10'd0, 1'b1, 1'b0, 8'd255, 16'd300);

    // Start is ignored in RUN; positive offset +15.
    branch_en = 1'b0; one = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start_in_run", 10'd1, 1'b1, 1'b0, 8'd255, 16'd301);
    branch_en = 1'b1; one = 1'b1; target_idx = 5'b01111;
    tick();
    branch_en = 1'b0; one = 1'b0;
    chk_all("br_pos", 10'd16, 1'b1, 1'b0, 8'd255, 16'd302);

    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk_all("halt2", 10'd16, 1'b0, 1'b1, 8'd255, 16'd303);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart_clr", 10'd0, 1'b1, 1'b0, 8'd0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
